// File: rtl/morra_pkg.sv
// Shared types for the morra cinese match controller: move, result and FSM encodings.
`timescale 1ns/1ps
package morra_pkg;

    typedef enum logic [1:0] {
        MV_NONE    = 2'b00,
        MV_SASSO   = 2'b01,
        MV_CARTA   = 2'b10,
        MV_FORBICE = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_TIE  = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_END  = 2'b10
    } state_t;

    // True when move a defeats move b (both assumed real moves).
    function automatic logic beats(input move_t a, input move_t b);
        return (a == MV_CARTA   && b == MV_SASSO)   ||
               (a == MV_SASSO   && b == MV_FORBICE) ||
               (a == MV_FORBICE && b == MV_CARTA);
    endfunction

endpackage

// File: rtl/morra_judge.sv
// Combinational manche judge: scores two moves and voids a win that repeats
// the previous winner's move by the same player.
`timescale 1ns/1ps
module morra_judge
    import morra_pkg::*;
(
    input  move_t   i_p1,
    input  move_t   i_p2,
    input  result_t i_last_res,
    input  move_t   i_last_move,
    output result_t o_res
);

    result_t w_raw;
    move_t   w_win_move;

    always_comb begin
        w_raw = RES_NONE;
        if (i_p1 == MV_NONE && i_p2 == MV_NONE)
            w_raw = RES_NONE;
        else if (i_p1 == MV_NONE)
            w_raw = RES_P2;
        else if (i_p2 == MV_NONE)
            w_raw = RES_P1;
        else if (i_p1 == i_p2)
            w_raw = RES_TIE;
        else if (beats(i_p1, i_p2))
            w_raw = RES_P1;
        else
            w_raw = RES_P2;

        w_win_move = (w_raw == RES_P1) ? i_p1 : i_p2;

        o_res = w_raw;
        // A last-win of RES_NONE never matches a real win, so the rule is inert then.
        if ((w_raw == RES_P1 || w_raw == RES_P2) &&
            w_raw == i_last_res && w_win_move == i_last_move)
            o_res = RES_NONE;
    end

endmodule

// File: rtl/morra_cinese_param.sv
// Morra cinese partita controller: one manche per clock in PLAY, early win on lead, draw/win at max.
// Optional feature macro MORRA_NO_REPEAT_EN: a winner may not win again with the same move.
`timescale 1ns/1ps
module morra_cinese_param
    import morra_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int MIN_MANCHE = 4,
    parameter int LEAD_WIN   = 2
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] PRIMO,
    input  logic [1:0] SECONDO,
    input  logic       INIZIA,
    output logic [1:0] MANCHE,
    output logic [1:0] PARTITA,
    output logic       IN_GIOCO
);

    localparam logic [CNT_W-1:0]      MIN_C    = CNT_W'(MIN_MANCHE);
    localparam logic [CNT_W:0]        LEAD_C   = (CNT_W+1)'(LEAD_WIN);
    localparam logic signed [CNT_W:0] LEAD_ONE = (CNT_W+1)'(1);

    state_t                r_state,   w_state_n;
    logic [CNT_W-1:0]      r_count,   w_count_n;
    logic [CNT_W-1:0]      r_max,     w_max_n;
    logic signed [CNT_W:0] r_lead,    w_lead_n;
    result_t               r_manche,  w_manche_n;
    result_t               r_partita, w_partita_n;
    result_t               w_res;
    result_t               w_last_res;
    move_t                 w_last_move;
    move_t                 w_p1, w_p2;

    function automatic logic [CNT_W:0] lead_mag(input logic signed [CNT_W:0] v);
        return v[CNT_W] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic result_t partita_of(input logic signed [CNT_W:0] v);
        if (v == '0)
            return RES_TIE;
        return v[CNT_W] ? RES_P2 : RES_P1;
    endfunction

    assign w_p1 = move_t'(PRIMO);
    assign w_p2 = move_t'(SECONDO);

`ifdef MORRA_NO_REPEAT_EN
    result_t r_last_res,  w_last_res_n;
    move_t   r_last_move, w_last_move_n;
    assign w_last_res  = r_last_res;
    assign w_last_move = r_last_move;
`else
    assign w_last_res  = RES_NONE;
    assign w_last_move = MV_NONE;
`endif

    morra_judge u_judge (
        .i_p1        (w_p1),
        .i_p2        (w_p2),
        .i_last_res  (w_last_res),
        .i_last_move (w_last_move),
        .o_res       (w_res)
    );

    always_comb begin
        w_state_n   = r_state;
        w_count_n   = r_count;
        w_max_n     = r_max;
        w_lead_n    = r_lead;
        w_manche_n  = RES_NONE;
        w_partita_n = RES_NONE;
`ifdef MORRA_NO_REPEAT_EN
        w_last_res_n  = r_last_res;
        w_last_move_n = r_last_move;
`endif
        // INIZIA wins over any manche sampled on the same edge.
        if (INIZIA) begin
            w_max_n   = CNT_W'({PRIMO, SECONDO}) + MIN_C;
            w_count_n = '0;
            w_lead_n  = '0;
            w_state_n = ST_PLAY;
`ifdef MORRA_NO_REPEAT_EN
            w_last_res_n  = RES_NONE;
            w_last_move_n = MV_NONE;
`endif
        end else if (r_state == ST_PLAY) begin
            w_manche_n = w_res;
            if (w_res != RES_NONE) begin
                w_count_n = r_count + CNT_W'(1);
                if (w_res == RES_P1)
                    w_lead_n = r_lead + LEAD_ONE;
                else if (w_res == RES_P2)
                    w_lead_n = r_lead - LEAD_ONE;
`ifdef MORRA_NO_REPEAT_EN
                if (w_res == RES_P1 || w_res == RES_P2) begin
                    w_last_res_n  = w_res;
                    w_last_move_n = (w_res == RES_P1) ? w_p1 : w_p2;
                end
`endif
                if ((w_count_n >= MIN_C && lead_mag(w_lead_n) >= LEAD_C) ||
                    w_count_n == r_max) begin
                    w_partita_n = partita_of(w_lead_n);
                    w_state_n   = ST_END;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_max     <= '0;
            r_lead    <= '0;
            r_manche  <= RES_NONE;
            r_partita <= RES_NONE;
`ifdef MORRA_NO_REPEAT_EN
            r_last_res  <= RES_NONE;
            r_last_move <= MV_NONE;
`endif
        end else begin
            r_state   <= w_state_n;
            r_count   <= w_count_n;
            r_max     <= w_max_n;
            r_lead    <= w_lead_n;
            r_manche  <= w_manche_n;
            r_partita <= w_partita_n;
`ifdef MORRA_NO_REPEAT_EN
            r_last_res  <= w_last_res_n;
            r_last_move <= w_last_move_n;
`endif
        end
    end

    assign MANCHE   = r_manche;
    assign PARTITA  = r_partita;
    assign IN_GIOCO = (r_state == ST_PLAY);

endmodule

// File: tb/tb_morra_cinese_param.sv
// Table-driven scoreboard bench for morra_cinese_param at default parameters.
`timescale 1ns/1ps
module tb_morra_cinese_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] PRIMO, SECONDO;
    logic       INIZIA;
    logic [1:0] MANCHE, PARTITA;
    logic       IN_GIOCO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ini;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] m;
        logic [1:0] p;
        logic       g;
    } vec_t;

    typedef struct {
        logic [1:0] m;
        logic [1:0] p;
        logic       g;
        int         id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    morra_cinese_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PRIMO    (PRIMO),
        .SECONDO  (SECONDO),
        .INIZIA   (INIZIA),
        .MANCHE   (MANCHE),
        .PARTITA  (PARTITA),
        .IN_GIOCO (IN_GIOCO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %b want %b", nm, id, act, exp);
        end
    endtask

    task automatic add(input logic ini, input logic [1:0] p1, input logic [1:0] p2,
                       input logic [1:0] m, input logic [1:0] p, input logic g);
        vec_t v;
        v.ini = ini; v.p1 = p1; v.p2 = p2; v.m = m; v.p = p; v.g = g;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        INIZIA  = v.ini;
        PRIMO   = v.p1;
        SECONDO = v.p2;
        e.m = v.m; e.p = v.p; e.g = v.g; e.id = id;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        INIZIA  = 1'b0;
        PRIMO   = 2'b00;
        SECONDO = 2'b00;
    endtask

    // Monitor: compares each registered result one step after its sampling edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("MANCHE",   e.id, MANCHE,          e.m);
            chk("PARTITA",  e.id, PARTITA,         e.p);
            chk("IN_GIOCO", e.id, {1'b0, IN_GIOCO}, {1'b0, e.g});
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n   = 1'b0;
        INIZIA  = 1'b0;
        PRIMO   = 2'b00;
        SECONDO = 2'b00;

        // Early P1 win at default max 4, IDLE/END ignore moves
        add(0, 2'b01, 2'b11, 2'b00, 2'b00, 0);  // 0 IDLE
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1);  // 1 start, max 4
        add(0, 2'b01, 2'b11, 2'b01, 2'b00, 1);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
        add(0, 2'b11, 2'b10, 2'b01, 2'b00, 1);
        add(0, 2'b01, 2'b11, 2'b01, 2'b01, 0);  // 5 ends
        add(0, 2'b01, 2'b11, 2'b00, 2'b00, 0);  // 6 END ignores
        // Invalid manches, then repeat rule
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1);  // 7 max 4
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00, 1);  // 11 P2 wins with carta
`ifdef MORRA_NO_REPEAT_EN
        add(0, 2'b01, 2'b10, 2'b00, 2'b00, 1);  // 12 repeat voided
        add(0, 2'b10, 2'b11, 2'b10, 2'b00, 1);
        add(0, 2'b11, 2'b01, 2'b10, 2'b00, 1);  // 14 count 3
        add(0, 2'b01, 2'b10, 2'b10, 2'b10, 0);  // 15 count 4, ends
`else
        add(0, 2'b01, 2'b10, 2'b10, 2'b00, 1);  // 12 repeat accepted
        add(0, 2'b10, 2'b11, 2'b10, 2'b00, 1);
        add(0, 2'b11, 2'b01, 2'b10, 2'b10, 0);  // 14 count 4, ends
        add(0, 2'b01, 2'b10, 2'b00, 2'b00, 0);  // 15 END
`endif
        // Draw at max 5
        add(1, 2'b00, 2'b01, 2'b00, 2'b00, 1);  // 16 max 5
        add(0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00, 1);
        add(0, 2'b11, 2'b10, 2'b01, 2'b00, 1);
        add(0, 2'b10, 2'b11, 2'b10, 2'b00, 1);  // 20 count 4, lead 0
        add(0, 2'b01, 2'b01, 2'b11, 2'b11, 0);  // 21 tie hits max
        // Restart from END, then INIZIA coincident with a valid manche
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1);  // 22 max 4
        add(0, 2'b01, 2'b11, 2'b01, 2'b00, 1);
        add(1, 2'b00, 2'b10, 2'b00, 2'b00, 1);  // 24 discarded, max 6
        add(0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
        add(0, 2'b01, 2'b01, 2'b11, 2'b00, 1);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00, 1);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00, 1);  // 28 count 4
        add(0, 2'b10, 2'b10, 2'b11, 2'b00, 1);
        add(0, 2'b11, 2'b10, 2'b01, 2'b01, 0);  // 30 count 6 == max

        #2;
        chk("rst MANCHE",   -1, MANCHE,          2'b00);
        chk("rst PARTITA",  -1, PARTITA,         2'b00);
        chk("rst IN_GIOCO", -1, {1'b0, IN_GIOCO}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i], i);
        idle();

        // Reset in the middle of a partita
        vecs.delete();
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
        add(0, 2'b11, 2'b10, 2'b01, 2'b00, 1);
        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i], 100 + i);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async MANCHE",   200, MANCHE,          2'b00);
        chk("async PARTITA",  200, PARTITA,         2'b00);
        chk("async IN_GIOCO", 200, {1'b0, IN_GIOCO}, 2'b00);
        @(posedge clk);
        #1;
        chk("held IN_GIOCO",  201, {1'b0, IN_GIOCO}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Play resumes from a clean score: early win needs four fresh manches
        vecs.delete();
        add(0, 2'b01, 2'b11, 2'b00, 2'b00, 0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(0, 2'b01, 2'b11, 2'b01, 2'b00, 1);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
        add(0, 2'b11, 2'b10, 2'b01, 2'b00, 1);
        add(0, 2'b01, 2'b11, 2'b01, 2'b01, 0);
        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i], 300 + i);
        idle();
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
